// File: rtl/core_pkg.sv
// Shared types for the data-TCM responder.
// Size encoding, ext-port FSM states, byte-enable width.
package core_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        EXT_IDLE  = 2'b00,
        EXT_GRANT = 2'b01,
        EXT_RESP  = 2'b10
    } ext_state_e;

    localparam int DTCM_BE_W = 4;

endpackage

// File: rtl/dtcm_ram.sv
// Single-port 2^AW x 32 SRAM, byte-write enables, registered read.
// Behavioural stand-in for a foundry macro; contents are never reset.
module dtcm_ram
    import core_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [DTCM_BE_W-1:0] be,
    input  logic [AW-1:0]        addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Byte-masked write or full-word registered read.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < DTCM_BE_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (en && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/dtcm_ctrl.sv
// Data-TCM responder: CPU load/store port plus a lower-priority ext port.
// Optional DTCM_ZERO_INIT_EN zero-fills the array after reset.
module dtcm_ctrl
    import core_pkg::*;
#(
    parameter int AW          = 12,
    parameter int ZERO_ON_ERR = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dtcm_en,
    input  logic          dtcm_we,
    input  logic [1:0]    dtcm_size,
    input  logic [31:0]   dtcm_addr,
    input  logic [31:0]   dtcm_wdata,
    output logic [31:0]   dtcm_rdata,
    output logic          dtcm_err,
    input  logic          ext_valid,
    output logic          ext_ready,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [31:0]   ext_wdata,
    output logic          ext_rvalid,
    output logic [31:0]   ext_rdata,
    output logic          init_busy
);

    ext_state_e           state;
    logic                 cpu_go;
    logic                 cpu_rd_q;
    logic [31:0]          cpu_hold;
    logic [31:0]          ext_hold;
    logic                 st_bad;
    logic                 st_ok;
    logic [DTCM_BE_W-1:0] st_be;
    logic [31:0]          st_data;
    logic [AW-1:0]        init_cnt;
    logic                 ram_en;
    logic                 ram_we;
    logic [DTCM_BE_W-1:0] ram_be;
    logic [AW-1:0]        ram_addr;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_q;
    logic                 unused_addr;

    assign unused_addr = ^dtcm_addr[31:AW+2];

`ifdef DTCM_ZERO_INIT_EN
    logic init_q;

    // Walk every word once after reset, writing zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q   <= 1'b1;
            init_cnt <= '0;
        end else if (init_q) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) init_q <= 1'b0;
        end
    end

    assign init_busy = init_q;
`else
    assign init_cnt  = '0;
    assign init_busy = 1'b0;
`endif

    assign cpu_go    = dtcm_en && !init_busy;
    assign ext_ready = (state == EXT_IDLE) && ext_valid
                       && !dtcm_en && !init_busy;

    // Store lane decode; half ignores addr[0], word ignores addr[1:0].
    always_comb begin
        st_bad  = 1'b0;
        st_be   = '0;
        st_data = dtcm_wdata;
        case (dtcm_size)
            SZ_B: begin
                st_be   = 4'b0001 << dtcm_addr[1:0];
                st_data = {4{dtcm_wdata[7:0]}};
            end
            SZ_H: begin
                st_bad  = dtcm_addr[0];
                st_be   = 4'b0011 << {dtcm_addr[1], 1'b0};
                st_data = {2{dtcm_wdata[15:0]}};
            end
            SZ_W: begin
                st_bad  = (dtcm_addr[1:0] != 2'b00);
                st_be   = 4'b1111;
            end
            default: begin
                st_bad  = 1'b1;
                st_be   = '0;
            end
        endcase
        st_ok = !st_bad || ((ZERO_ON_ERR == 0) && (dtcm_size != 2'b11));
    end

    // Array port mux: init walker, then CPU, then ext.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = dtcm_addr[AW+1:2];
        ram_wdata = st_data;
        if (init_busy) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_be    = '1;
            ram_addr  = init_cnt;
            ram_wdata = '0;
        end else if (dtcm_en) begin
            ram_en = !dtcm_we || st_ok;
            ram_we = dtcm_we;
            ram_be = st_be;
        end else if (ext_ready) begin
            ram_en    = 1'b1;
            ram_we    = ext_we;
            ram_be    = '1;
            ram_addr  = ext_addr;
            ram_wdata = ext_wdata;
        end
    end

    dtcm_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    // Ext FSM, sticky error, and read-data holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EXT_IDLE;
            ext_rvalid <= 1'b0;
            cpu_rd_q   <= 1'b0;
            cpu_hold   <= '0;
            ext_hold   <= '0;
            dtcm_err   <= 1'b0;
        end else begin
            cpu_rd_q <= cpu_go && !dtcm_we;
            if (cpu_rd_q)   cpu_hold <= ram_q;
            if (ext_rvalid) ext_hold <= ram_q;
            if (cpu_go && dtcm_we && st_bad) dtcm_err <= 1'b1;
            case (state)
                EXT_IDLE: begin
                    if (ext_ready && !ext_we) begin
                        state      <= EXT_RESP;
                        ext_rvalid <= 1'b1;
                    end
                end
                EXT_RESP: begin
                    state      <= EXT_IDLE;
                    ext_rvalid <= 1'b0;
                end
                default: begin
                    state      <= EXT_IDLE;
                    ext_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign dtcm_rdata = cpu_rd_q ? ram_q : cpu_hold;
    assign ext_rdata  = ext_rvalid ? ram_q : ext_hold;

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Self-checking bench for dtcm_ctrl against a byte-addressed memory model.
// Optional DTCM_ZERO_INIT_EN exercises the zero-fill walker.
module tb_dtcm_ctrl;

    localparam int AW   = 12;
    localparam int NB   = 2048;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          dtcm_en = 1'b0;
    logic          dtcm_we = 1'b0;
    logic [1:0]    dtcm_size = 2'b00;
    logic [31:0]   dtcm_addr = '0;
    logic [31:0]   dtcm_wdata = '0;
    logic [31:0]   dtcm_rdata;
    logic          dtcm_err;
    logic          ext_valid = 1'b0;
    logic          ext_ready;
    logic          ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [31:0]   ext_wdata = '0;
    logic          ext_rvalid;
    logic [31:0]   ext_rdata;
    logic          init_busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mb [0:NB-1];
    bit         model_err;

    dtcm_ctrl #(.AW(AW), .ZERO_ON_ERR(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dtcm_en    (dtcm_en),
        .dtcm_we    (dtcm_we),
        .dtcm_size  (dtcm_size),
        .dtcm_addr  (dtcm_addr),
        .dtcm_wdata (dtcm_wdata),
        .dtcm_rdata (dtcm_rdata),
        .dtcm_err   (dtcm_err),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mword(input int a);
        int b;
        b = a & ~3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    function automatic void mstore(input int sz, input int a,
                                   input logic [31:0] d);
        int n;
        if (sz == 3) begin
            model_err = 1'b1;
            return;
        end
        n = 1 << sz;
        if ((a % n) != 0) begin
            model_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) mb[a+i] = d[8*i +: 8];
    endfunction

    function automatic void mext_write(input int w, input logic [31:0] d);
        for (int i = 0; i < 4; i++) mb[w*4+i] = d[8*i +: 8];
    endfunction

    task automatic cpu_store(input int sz, input int a, input logic [31:0] d);
        dtcm_en    = 1'b1;
        dtcm_we    = 1'b1;
        dtcm_size  = sz[1:0];
        dtcm_addr  = a;
        dtcm_wdata = d;
        tick();
        dtcm_en = 1'b0;
        dtcm_we = 1'b0;
        mstore(sz, a, d);
    endtask

    task automatic cpu_load(input int a, output logic [31:0] q);
        dtcm_en   = 1'b1;
        dtcm_we   = 1'b0;
        dtcm_addr = a;
        tick();
        dtcm_en = 1'b0;
        q = dtcm_rdata;
    endtask

    task automatic ext_read(input int w, output logic [31:0] q,
                            output bit ok, output bit rv);
        int n;
        ext_valid = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = w[AW-1:0];
        #1;
        n = 0;
        while (!ext_ready && n < 10) begin
            tick();
            n++;
        end
        ok = ext_ready;
        tick();
        ext_valid = 1'b0;
        q  = ext_rdata;
        rv = ext_rvalid;
        tick();
    endtask

    task automatic apply_reset(input bit wait_init);
        int n;
        dtcm_en   = 1'b0;
        ext_valid = 1'b0;
        reset_n   = 1'b0;
        repeat (2) tick();
        reset_n   = 1'b1;
        model_err = 1'b0;
`ifdef DTCM_ZERO_INIT_EN
        for (int i = 0; i < NB; i++) mb[i] = 8'h00;
        if (wait_init) begin
            n = 0;
            while (init_busy && n < 5000) begin
                tick();
                n++;
            end
            checks++;
            if (init_busy !== 1'b0) begin
                failures++;
                $display("FAIL init_timeout got=%b exp=0", init_busy);
            end
        end
`else
        n = 0;
        if (wait_init) n = 1;
`endif
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        checks++;
        if (dtcm_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_rdata got=%h exp=0", dtcm_rdata);
        end
        checks++;
        if (ext_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_ext_rdata got=%h exp=0", ext_rdata);
        end
        checks++;
        if ({ext_ready, ext_rvalid, dtcm_err} !== 3'b000) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=000",
                     {ext_ready, ext_rvalid, dtcm_err});
        end
        checks++;
`ifdef DTCM_ZERO_INIT_EN
        if (init_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_init_busy got=%b exp=1", init_busy);
        end
        apply_reset(1'b1);
`else
        if (init_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_init_busy got=%b exp=0", init_busy);
        end
`endif
    endtask

`ifdef DTCM_ZERO_INIT_EN
    task automatic test_init();
        int n;
        logic [31:0] q;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (8) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (init_busy !== 1'b1) begin
            failures++;
            $display("FAIL init_restart got=%b exp=1", init_busy);
        end
        tick();
        reset_n = 1'b1;
        n = 0;
        while (init_busy && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (n != (1 << AW)) begin
            failures++;
            $display("FAIL init_len got=%0d exp=%0d", n, 1 << AW);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_load($urandom_range(0, (1 << AW) - 1) * 4, q);
            checks++;
            if (q !== 32'h0) begin
                failures++;
                $display("FAIL init_zero got=%h exp=0", q);
            end
        end
    endtask
`endif

    task automatic prefill();
        for (int w = 0; w < NB / 4; w++) cpu_store(2, w * 4, $urandom);
    endtask

    task automatic test_byte_store();
        logic [31:0] q;
        cpu_store(0, 'h102, 32'h0000_00A5);
        cpu_load('h100, q);
        checks++;
        if (q !== mword('h100)) begin
            failures++;
            $display("FAIL sb_word got=%h exp=%h", q, mword('h100));
        end
        checks++;
        if (q[23:16] !== 8'hA5) begin
            failures++;
            $display("FAIL sb_lane got=%h exp=a5", q[23:16]);
        end
    endtask

    task automatic test_half_word();
        logic [31:0] q1, q2;
        cpu_store(1, 'h206, 32'h0000_BEEF);
        cpu_store(2, 'h300, 32'h1234_5678);
        cpu_load('h204, q1);
        cpu_load('h300, q2);
        checks++;
        if (q1[31:16] !== 16'hBEEF || q1 !== mword('h204)) begin
            failures++;
            $display("FAIL sh_word got=%h exp=%h", q1, mword('h204));
        end
        checks++;
        if (q2 !== 32'h1234_5678) begin
            failures++;
            $display("FAIL sw_b2b got=%h exp=12345678", q2);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] q, w0, w1, w2;
        checks++;
        if (dtcm_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clean got=%b exp=0", dtcm_err);
        end
        w0 = mword('h400);
        cpu_store(2, 'h401, $urandom);
        checks++;
        if (dtcm_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got=%b exp=1", dtcm_err);
        end
        cpu_load('h400, q);
        checks++;
        if (q !== w0) begin
            failures++;
            $display("FAIL sw_drop got=%h exp=%h", q, w0);
        end
        w1 = mword('h200);
        cpu_store(1, 'h203, $urandom);
        cpu_load('h200, q);
        checks++;
        if (q !== w1) begin
            failures++;
            $display("FAIL sh_drop got=%h exp=%h", q, w1);
        end
        w2 = mword('h208);
        cpu_store(3, 'h208, $urandom);
        cpu_load('h208, q);
        checks++;
        if (q !== w2) begin
            failures++;
            $display("FAIL sz11_drop got=%h exp=%h", q, w2);
        end
        cpu_load('h203, q);
        checks++;
        if (q !== w1) begin
            failures++;
            $display("FAIL lw_misal got=%h exp=%h", q, w1);
        end
        repeat (5) tick();
        checks++;
        if (dtcm_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", dtcm_err);
        end
    endtask

    task automatic test_ext_starve();
        int a;
        ext_valid = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = 'h040;
        for (int c = 0; c < 3; c++) begin
            a = $urandom_range(0, NB / 4 - 1) * 4;
            dtcm_en   = 1'b1;
            dtcm_we   = 1'b0;
            dtcm_addr = a;
            #1;
            checks++;
            if (ext_ready !== 1'b0) begin
                failures++;
                $display("FAIL starve_ready c=%0d got=%b exp=0", c, ext_ready);
            end
            tick();
            checks++;
            if (dtcm_rdata !== mword(a)) begin
                failures++;
                $display("FAIL starve_load got=%h exp=%h", dtcm_rdata, mword(a));
            end
        end
        dtcm_en = 1'b0;
        #1;
        checks++;
        if (ext_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready got=%b exp=1", ext_ready);
        end
        tick();
        ext_valid = 1'b0;
        checks++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== mword('h100)) begin
            failures++;
            $display("FAIL ext_resp rv=%b got=%h exp=%h",
                     ext_rvalid, ext_rdata, mword('h100));
        end
        tick();
        checks++;
        if (ext_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_pulse got=%b exp=0", ext_rvalid);
        end
    endtask

    task automatic test_ext_write();
        logic [31:0] q;
        ext_valid = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = 5;
        ext_wdata = 32'h0000_0AA5;
        #1;
        checks++;
        if (ext_ready !== 1'b1) begin
            failures++;
            $display("FAIL extw_ready got=%b exp=1", ext_ready);
        end
        tick();
        ext_valid = 1'b0;
        ext_we    = 1'b0;
        mext_write(5, 32'h0000_0AA5);
        checks++;
        if (ext_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL extw_noresp got=%b exp=0", ext_rvalid);
        end
        cpu_load('h14, q);
        checks++;
        if (q !== 32'h0000_0AA5) begin
            failures++;
            $display("FAIL extw_load got=%h exp=00000aa5", q);
        end
    endtask

    task automatic test_hold();
        logic [31:0] q, exp_hold, eq;
        bit ok, rv;
        int a;
        a = 'h180;
        cpu_load(a, q);
        exp_hold = mword(a);
        ext_read(9, eq, ok, rv);
        cpu_store(2, 'h184, $urandom);
        repeat (2) tick();
        checks++;
        if (dtcm_rdata !== exp_hold) begin
            failures++;
            $display("FAIL rdata_hold got=%h exp=%h", dtcm_rdata, exp_hold);
        end
        checks++;
        if (!ok || !rv || eq !== mword(36)) begin
            failures++;
            $display("FAIL hold_ext ok=%b rv=%b got=%h exp=%h",
                     ok, rv, eq, mword(36));
        end
        checks++;
        if (ext_rdata !== mword(36)) begin
            failures++;
            $display("FAIL ext_rdata_hold got=%h exp=%h", ext_rdata, mword(36));
        end
    endtask

    task automatic test_random();
        logic [31:0] q, d;
        bit ok, rv;
        int op, a, sz, w;
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    a = $urandom_range(0, NB - 1);
                    cpu_load(a, q);
                    checks++;
                    if (q !== mword(a)) begin
                        failures++;
                        $display("FAIL rnd_load a=%h got=%h exp=%h",
                                 a, q, mword(a));
                    end
                end
                1: begin
                    sz = $urandom_range(0, 3);
                    a  = $urandom_range(0, NB - 4);
                    cpu_store(sz, a, $urandom);
                end
                2: begin
                    w = $urandom_range(0, NB / 4 - 1);
                    d = $urandom;
                    ext_valid = 1'b1;
                    ext_we    = 1'b1;
                    ext_addr  = w[AW-1:0];
                    ext_wdata = d;
                    tick();
                    ext_valid = 1'b0;
                    ext_we    = 1'b0;
                    mext_write(w, d);
                end
                3: begin
                    w = $urandom_range(0, NB / 4 - 1);
                    ext_read(w, q, ok, rv);
                    checks++;
                    if (!ok || !rv || q !== mword(w * 4)) begin
                        failures++;
                        $display("FAIL rnd_ext w=%0d ok=%b rv=%b got=%h exp=%h",
                                 w, ok, rv, q, mword(w * 4));
                    end
                end
                default: tick();
            endcase
            checks++;
            if (dtcm_err !== model_err) begin
                failures++;
                $display("FAIL rnd_err got=%b exp=%b", dtcm_err, model_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        ext_valid = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = 3;
        tick();
        ext_valid = 1'b0;
        checks++;
        if (ext_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got=%b exp=1", ext_rvalid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ext_rvalid, dtcm_err} !== 2'b00 || dtcm_rdata !== 32'h0
            || ext_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset rv=%b err=%b rd=%h erd=%h exp=0",
                     ext_rvalid, dtcm_err, dtcm_rdata, ext_rdata);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (ext_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_abandon got=%b exp=0", ext_rvalid);
        end
    endtask

    initial begin
        test_reset();
`ifdef DTCM_ZERO_INIT_EN
        test_init();
`endif
        prefill();
        test_byte_store();
        test_half_word();
        test_misaligned();
        test_ext_starve();
        test_ext_write();
        test_hold();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
